// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA request/acknowledge front end.
package dma_pkg;
    localparam int NUM_CH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HLDA,
        SERVICE,
        RELEASE
    } arb_state_t;
endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request, bus-hold and service signals between the DMA arbiter and its neighbours.
interface dma_priority_arbiter_if import dma_pkg::*; #(
    parameter int NUM_CH = NUM_CH_DEF
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] DREQ;
    logic              HLDA;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] sw_req;
    logic              ctrl_dis;
    logic              rot_pri;
    logic              svc_done;
    logic              svc_valid;
    logic [CH_W-1:0]   svc_ch;
    logic [NUM_CH-1:0] sw_req_clr;

    // The arbiter side; the CPU, datapath and timing control form the other side.
    modport master (
        input  DREQ, HLDA, mask, sw_req, ctrl_dis, rot_pri, svc_done,
        output HRQ, DACK, svc_valid, svc_ch, sw_req_clr
    );

    modport slave (
        output DREQ, HLDA, mask, sw_req, ctrl_dis, rot_pri, svc_done,
        input  HRQ, DACK, svc_valid, svc_ch, sw_req_clr
    );
endinterface

// File: rtl/dma_prio_resolve.sv
// Combinational priority encoder: first eligible channel found searching upward from start, wrapping.
module dma_prio_resolve import dma_pkg::*; #(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic [NUM_CH-1:0]         elig,
    input  logic [$clog2(NUM_CH)-1:0] start,
    output logic [$clog2(NUM_CH)-1:0] winner,
    output logic                      any
);
    localparam int CH_W = $clog2(NUM_CH);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_CH) idx -= NUM_CH;
            if (!any && elig[CH_W'(idx)]) begin
                any    = 1'b1;
                winner = CH_W'(idx);
            end
        end
    end
endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style request front end: DREQ synchronisers, HRQ/HLDA handshake, one-at-a-time DACK grant.
module dma_priority_arbiter import dma_pkg::*; #(
    parameter int NUM_CH        = NUM_CH_DEF,
    parameter int SYNC_STAGES   = 2,
    parameter bit DREQ_ACT_HIGH = 1'b1,
    parameter bit DACK_ACT_HIGH = 1'b0
) (
    input logic                    CLK,
    input logic                    RESET_N,
    dma_priority_arbiter_if.master bus
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0] dreq_n, dreq_s, elig;
    logic [CH_W-1:0]   start_ptr, winner;
    logic              any;

    arb_state_t        state, next_state;
    logic              hrq_q, hrq_d, valid_q, valid_d;
    logic [NUM_CH-1:0] dack_q, dack_d, clr_q, clr_d;
    logic [CH_W-1:0]   ch_q, ch_d, ptr_q, ptr_d;

    // Normalise before the first flop so reset clears to "not requesting" for either polarity.
    assign dreq_n = DREQ_ACT_HIGH ? bus.DREQ : ~bus.DREQ;
    assign dreq_s = sync_q[SYNC_STAGES-1];
    assign elig   = bus.ctrl_dis ? '0 : ((dreq_s | bus.sw_req) & ~bus.mask);

    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: non-blocking so every stage samples its predecessor's old value.
        if (!RESET_N) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], dreq_n};
    end

    assign start_ptr = bus.rot_pri ? ptr_q : '0;

    dma_prio_resolve #(.NUM_CH(NUM_CH)) u_resolve (
        .elig   (elig),
        .start  (start_ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            hrq_q   <= 1'b0;
            valid_q <= 1'b0;
            dack_q  <= '0;
            clr_q   <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state   <= next_state;
            hrq_q   <= hrq_d;
            valid_q <= valid_d;
            dack_q  <= dack_d;
            clr_q   <= clr_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        // NOTE: every output defaulted first, so no path can infer a latch.
        next_state = state;
        hrq_d      = hrq_q;
        valid_d    = valid_q;
        dack_d     = dack_q;
        clr_d      = '0;
        ch_d       = ch_q;
        ptr_d      = ptr_q;
        unique case (state)
            IDLE: begin
                if (any) begin
                    hrq_d      = 1'b1;
                    next_state = WAIT_HLDA;
                end
            end
            WAIT_HLDA: begin
                if (bus.HLDA && any) begin
                    ch_d       = winner;
                    dack_d     = NUM_CH'(1) << winner;
                    valid_d    = 1'b1;
                    next_state = SERVICE;
                end else if (!any) begin
                    hrq_d      = 1'b0;
                    next_state = bus.HLDA ? RELEASE : IDLE;
                end
            end
            SERVICE: begin
                // A CPU abort (HLDA low) wins over a coincident svc_done.
                if (!bus.HLDA || bus.svc_done) begin
                    hrq_d   = 1'b0;
                    valid_d = 1'b0;
                    dack_d  = '0;
                    if (bus.HLDA) begin
                        clr_d      = NUM_CH'(1) << ch_q;
                        next_state = RELEASE;
                        if (bus.rot_pri)
                            ptr_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            RELEASE: begin
                if (!bus.HLDA) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.HRQ        = hrq_q;
    assign bus.DACK       = DACK_ACT_HIGH ? dack_q : ~dack_q;
    assign bus.svc_valid  = valid_q;
    assign bus.svc_ch     = ch_q;
    assign bus.sw_req_clr = clr_q;
endmodule
